// File: rtl/decode_stage.sv
// Decode stage: IF/ID pipeline register, field extraction, and a register file
// whose top index reads back the fetched PC+8 instead of storage.
module decode_stage #(
    parameter int WIDTH = 22,
    parameter int NREGS = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stallD,
    input  logic                     flushD,
    input  logic [WIDTH-1:0]         instruction_in,
    input  logic [WIDTH-1:0]         pc_plus_8_in,
    input  logic                     reg_write_w,
    input  logic [$clog2(NREGS)-1:0] write_reg_w,
    input  logic [WIDTH-1:0]         result_w,
    output logic                     valid_out,
    output logic [2:0]               opcode_out,
    output logic                     imm_sel_out,
    output logic [3:0]               rd_out,
    output logic [3:0]               rn_out,
    output logic [3:0]               rm_out,
    output logic [WIDTH-1:0]         rd1_out,
    output logic [WIDTH-1:0]         rd2_out,
    output logic [WIDTH-1:0]         imm_ext_out
);
    localparam int             IW     = $clog2(NREGS);
    localparam logic [IW-1:0]  PC_IDX = IW'(NREGS - 1);
    localparam int             I_BIT  = WIDTH - 4;
    localparam int             RD_HI  = WIDTH - 5;
    localparam int             RN_HI  = WIDTH - 9;
    localparam int             RM_HI  = WIDTH - 13;
    localparam int             IMM_W  = 10;

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] pc8_q, pc8_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc8_d   = pc8_q;
        if (flushD) begin
            valid_d = 1'b0;
            instr_d = '0;
            pc8_d   = '0;
        end else if (!stallD) begin
            valid_d = 1'b1;
            instr_d = instruction_in;
            pc8_d   = pc_plus_8_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc8_q   <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc8_q   <= pc8_d;
        end
    end

    // Only indices below PC_IDX have storage; the top index aliases pc8.
    logic [WIDTH-1:0] regs_q [NREGS-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS - 1; i++) regs_q[i] <= '0;
        end else if (reg_write_w && write_reg_w != PC_IDX) begin
            regs_q[write_reg_w] <= result_w;
        end
    end

    // Bypass is gated by reset so every output reads zero while reset is held.
    logic          bypass_en;
    logic [IW-1:0] rd_idx  [2];
    logic [WIDTH-1:0] rd_data [2];

    assign bypass_en = reset & reg_write_w & (write_reg_w != PC_IDX);
    assign rd_idx[0] = instr_q[RN_HI -: IW];
    assign rd_idx[1] = instr_q[RM_HI -: IW];

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = '0;
            if (rd_idx[p] == PC_IDX)
                rd_data[p] = pc8_q;
            else if (bypass_en && write_reg_w == rd_idx[p])
                rd_data[p] = result_w;
            else
                rd_data[p] = regs_q[rd_idx[p]];
        end
    end

    logic [WIDTH-1:0] fld;
    assign fld = valid_q ? instr_q : '0;

    assign valid_out   = valid_q;
    assign opcode_out  = fld[WIDTH-1 -: 3];
    assign imm_sel_out = fld[I_BIT];
    assign rd_out      = fld[RD_HI -: 4];
    assign rn_out      = fld[RN_HI -: 4];
    assign rm_out      = fld[RM_HI -: 4];
    assign rd1_out     = rd_data[0];
    assign rd2_out     = rd_data[1];
    assign imm_ext_out = {{(WIDTH-IMM_W){fld[IMM_W-1]}}, fld[IMM_W-1:0]};
endmodule

// File: tb/tb_decode_stage.sv
// Randomized and directed bench for decode_stage against a behavioural model
// of the pipeline register and register file.
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        reset, stallD, flushD, reg_write_w;
    logic [21:0] instruction_in, pc_plus_8_in, result_w;
    logic [3:0]  write_reg_w;
    logic        valid_out, imm_sel_out;
    logic [2:0]  opcode_out;
    logic [3:0]  rd_out, rn_out, rm_out;
    logic [21:0] rd1_out, rd2_out, imm_ext_out;

    decode_stage dut (
        .clk(clk), .reset(reset), .stallD(stallD), .flushD(flushD),
        .instruction_in(instruction_in), .pc_plus_8_in(pc_plus_8_in),
        .reg_write_w(reg_write_w), .write_reg_w(write_reg_w), .result_w(result_w),
        .valid_out(valid_out), .opcode_out(opcode_out), .imm_sel_out(imm_sel_out),
        .rd_out(rd_out), .rn_out(rn_out), .rm_out(rm_out),
        .rd1_out(rd1_out), .rd2_out(rd2_out), .imm_ext_out(imm_ext_out)
    );

    always #5 clk = ~clk;

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Behavioural model state
    logic [21:0] m_regs [16];
    logic        m_valid;
    logic [21:0] m_instr, m_pc8;

    function automatic void m_clear();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_valid = 1'b0; m_instr = '0; m_pc8 = '0;
    endfunction

    function automatic logic [21:0] m_read(input logic [3:0] idx);
        if (idx == 4'd15) return m_pc8;
        if (reset && reg_write_w && write_reg_w == idx) return result_w;
        return m_regs[idx];
    endfunction

    function automatic logic [82:0] m_out();
        logic [21:0] f;
        f = m_valid ? m_instr : 22'd0;
        return {m_valid, f[21:19], f[18], f[17:14], f[13:10], f[9:6],
                m_read(m_instr[13:10]), m_read(m_instr[9:6]), 22'($signed(f[9:0]))};
    endfunction

    function automatic logic [82:0] dut_out();
        return {valid_out, opcode_out, imm_sel_out, rd_out, rn_out, rm_out,
                rd1_out, rd2_out, imm_ext_out};
    endfunction

    task automatic drive(input logic [21:0] ins, input logic [21:0] pc, input logic st,
                         input logic fl, input logic we, input logic [3:0] wr,
                         input logic [21:0] res);
        instruction_in = ins; pc_plus_8_in = pc; stallD = st; flushD = fl;
        reg_write_w = we; write_reg_w = wr; result_w = res;
    endtask

    // Advance one clock, update the model from the inputs seen at the edge.
    task automatic tick();
        @(posedge clk);
        if (!reset) m_clear();
        else begin
            if (reg_write_w && write_reg_w != 4'd15) m_regs[write_reg_w] = result_w;
            if (flushD) begin m_valid = 1'b0; m_instr = '0; m_pc8 = '0; end
            else if (!stallD) begin m_valid = 1'b1; m_instr = instruction_in; m_pc8 = pc_plus_8_in; end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [82:0] exp_v, got_v;
        reset = 1'b0; m_clear();
        drive(22'h3FFFFF, 22'h3FFFFF, 1'b0, 1'b0, 1'b1, 4'd0, 22'h2AAAAA);
        tick(); tick(); #1;
        exp_v = m_out(); got_v = dut_out(); cmp_cnt++;
        if (got_v !== exp_v || got_v !== 83'd0) begin
            err_cnt++; $display("FAIL reset_outputs got=%h exp=%h", got_v, exp_v);
        end
        reset = 1'b1;
    endtask

    task automatic test_load();
        drive(22'h0A3C45, 22'h000008, 1'b0, 1'b0, 1'b0, 4'd0, 22'd0);
        tick(); #1;
        cmp_cnt++;
        if ({valid_out, opcode_out, rd_out, rm_out, rn_out, rd1_out} !==
            {1'b1, 3'd1, 4'd8, 4'd1, 4'd15, 22'h000008}) begin
            err_cnt++;
            $display("FAIL load_fields got v=%0b op=%0d rd=%0d rm=%0d rn=%0d rd1=%h exp v=1 op=1 rd=8 rm=1 rn=15 rd1=000008",
                     valid_out, opcode_out, rd_out, rm_out, rn_out, rd1_out);
        end
    endtask

    task automatic test_bypass();
        logic [82:0] exp_v, got_v;
        // rn=15, rm=3
        drive(22'h003CC0, 22'h00ABCD, 1'b0, 1'b0, 1'b0, 4'd0, 22'd0);
        tick();
        drive(22'h000000, 22'h000000, 1'b1, 1'b0, 1'b1, 4'd3, 22'h012345); #1;
        cmp_cnt++;
        if (rd2_out !== 22'h012345) begin
            err_cnt++; $display("FAIL bypass_same_cycle got=%h exp=012345", rd2_out);
        end
        tick();
        drive(22'h000000, 22'h000000, 1'b1, 1'b0, 1'b1, 4'd15, 22'h3FFFFF); #1;
        cmp_cnt++;
        if (rd2_out !== 22'h012345 || rd1_out !== 22'h00ABCD) begin
            err_cnt++; $display("FAIL bypass_after_edge_r15 got rd2=%h rd1=%h exp rd2=012345 rd1=00abcd", rd2_out, rd1_out);
        end
        tick(); reg_write_w = 1'b0; #1;
        exp_v = m_out(); got_v = dut_out(); cmp_cnt++;
        if (got_v !== exp_v || rd1_out !== 22'h00ABCD) begin
            err_cnt++; $display("FAIL r15_write_ignored got=%h exp=%h", got_v, exp_v);
        end
    endtask

    task automatic test_stall_flush();
        logic [82:0] frozen, exp_v, got_v;
        drive(22'h15A5A5, 22'h000100, 1'b0, 1'b0, 1'b0, 4'd0, 22'd0);
        tick(); #1; frozen = dut_out();
        for (int i = 0; i < 3; i++) begin
            drive(22'($urandom), 22'($urandom), 1'b1, 1'b0, 1'b0, 4'd0, 22'd0);
            tick(); #1;
            exp_v = m_out(); got_v = dut_out(); cmp_cnt++;
            if (got_v !== exp_v || got_v !== frozen) begin
                err_cnt++; $display("FAIL stall_hold[%0d] got=%h exp=%h", i, got_v, exp_v);
            end
        end
        drive(22'h3FFFFF, 22'h3FFFFF, 1'b1, 1'b1, 1'b0, 4'd0, 22'd0);
        tick(); stallD = 1'b0; flushD = 1'b0; #1;
        got_v = dut_out(); cmp_cnt++;
        // rd1/rd2 read R0 which still holds 0
        if (got_v !== 83'd0) begin
            err_cnt++; $display("FAIL flush_over_stall got=%h exp=0", got_v);
        end
    endtask

    task automatic test_sign_ext();
        logic [21:0] ins_a [2];
        logic [21:0] exp_a [2];
        ins_a[0] = 22'h040200; exp_a[0] = 22'h3FFE00;
        ins_a[1] = 22'h0401FF; exp_a[1] = 22'h0001FF;
        for (int i = 0; i < 2; i++) begin
            drive(ins_a[i], 22'd0, 1'b0, 1'b0, 1'b0, 4'd0, 22'd0);
            tick(); #1;
            cmp_cnt++;
            if (imm_ext_out !== exp_a[i] || imm_sel_out !== 1'b1) begin
                err_cnt++; $display("FAIL sign_ext[%0d] got=%h I=%0b exp=%h I=1", i, imm_ext_out, imm_sel_out, exp_a[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [82:0] got_v;
        // rn=5, rm=5
        drive(22'h001540, 22'h000010, 1'b0, 1'b0, 1'b1, 4'd5, 22'h000ABC);
        tick(); reg_write_w = 1'b0; #1;
        cmp_cnt++;
        if (rd1_out !== 22'h000ABC) begin
            err_cnt++; $display("FAIL r5_written got=%h exp=000abc", rd1_out);
        end
        #2; reset = 1'b0; m_clear(); #1;
        got_v = dut_out(); cmp_cnt++;
        if (got_v !== 83'd0) begin
            err_cnt++; $display("FAIL async_reset got=%h exp=0", got_v);
        end
        @(negedge clk); reset = 1'b1;
        drive(22'h001540, 22'h000020, 1'b0, 1'b0, 1'b0, 4'd0, 22'd0);
        tick(); #1;
        cmp_cnt++;
        if ({valid_out, rn_out, rd1_out, rd2_out} !== {1'b1, 4'd5, 22'd0, 22'd0}) begin
            err_cnt++; $display("FAIL reload_after_reset got v=%0b rn=%0d rd1=%h rd2=%h exp v=1 rn=5 rd1=0 rd2=0",
                                valid_out, rn_out, rd1_out, rd2_out);
        end
    endtask

    task automatic test_random();
        logic [82:0] exp_v, got_v;
        logic [3:0]  wr;
        for (int i = 0; i < 400; i++) begin
            wr = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) wr = m_instr[13:10];
            if ($urandom_range(0, 2) == 0) wr = m_instr[9:6];
            drive(22'($urandom), 22'($urandom), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0, 1'($urandom), wr, 22'($urandom));
            #1;
            exp_v = m_out(); got_v = dut_out(); cmp_cnt++;
            if (got_v !== exp_v) begin
                err_cnt++; $display("FAIL random[%0d] got=%h exp=%h", i, got_v, exp_v);
            end
            tick();
        end
    endtask

    initial begin
        m_clear();
        reset = 1'b0;
        drive(22'd0, 22'd0, 1'b0, 1'b0, 1'b0, 4'd0, 22'd0);
        @(negedge clk);
        test_reset();
        test_load();
        test_bypass();
        test_stall_flush();
        test_sign_ext();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 22, the datapath, instruction and register width.
REQ-002 SHALL have parameter NREGS, default 16, the register count; index width is 4.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port stallD, input, 1, which holds the IF/ID register.
REQ-006 SHALL have port flushD, input, 1, which loads a bubble into the IF/ID register.
REQ-007 SHALL have port instruction_in, input, 22, the instruction from fetch.
REQ-008 SHALL have port pc_plus_8_in, input, 22, the PC-relative value from fetch.
REQ-009 SHALL have port reg_write_w, input, 1, the writeback enable.
REQ-010 SHALL have port write_reg_w, input, 4, the writeback register index.
REQ-011 SHALL have port result_w, input, 22, the writeback data.
REQ-012 SHALL have port valid_out, output, 1, which is high when the IF/ID register holds a real instruction.
REQ-013 SHALL have port opcode_out, output, 3, equal to instr[21:19].
REQ-014 SHALL have port imm_sel_out, output, 1, equal to instr[18].
REQ-015 SHALL have ports rd_out, rn_out and rm_out, output, 4 each, equal to instr[17:14], instr[13:10] and instr[9:6].
REQ-016 SHALL have ports rd1_out and rd2_out, output, 22 each, the register-file read data for rn and rm.
REQ-017 SHALL have port imm_ext_out, output, 22, equal to instr[9:0] sign-extended to 22 bits.

Function
REQ-018 SHALL contain an IF/ID register of {valid, instr[21:0], pc8[21:0]}.
REQ-019 IF/ID update priority SHALL be flushD, then stallD, then normal load.
- flushD=1: instr=0, valid=0, pc8=0.
- stallD=1, flushD=0: hold all fields.
- Otherwise: load instruction_in, pc_plus_8_in and valid=1.
REQ-020 All decode outputs SHALL be combinational from the IF/ID register, giving a latency of one cycle from fetch.
REQ-021 When valid=0, opcode_out, imm_sel_out, rd_out, rn_out, rm_out and imm_ext_out SHALL all be 0.
REQ-022 The register file SHALL hold 16 x 22-bit registers R0..R15.
- Write on the rising edge when reg_write_w=1 and write_reg_w!=15.
- A write to R15 SHALL be ignored.
REQ-023 A read of index 15 SHALL return the IF/ID pc8 field, not storage.
REQ-024 Same-cycle writeback bypass:
- If reg_write_w=1 and write_reg_w equals the read index and the index is not 15, read data SHALL equal result_w.
- This removes the W-to-D hazard.
REQ-025 Writeback SHALL proceed regardless of stallD and flushD.
REQ-026 The rd1_out and rd2_out ports SHALL be independent; both may read the same index, including through the bypass.
REQ-027 The imm_ext_out port SHALL replicate instr[9] into bits 21:10.
REQ-028 The block SHALL contain no other state; hazard detection is external.

Reset
REQ-029 While reset=0, asynchronously and regardless of clk:
- IF/ID valid=0, instr=0 and pc8=0.
- All 15 storage registers = 0.
REQ-030 During reset, all outputs SHALL read 0, including rd1_out and rd2_out for index 15, since pc8=0.
REQ-031 Reset asserted mid-stall or mid-write SHALL override both.
- The first edge after release SHALL perform a normal load.
REQ-032 Reset deassertion SHALL be synchronized externally.

Verification
REQ-033 Reset then load: load instruction_in=0x0A3C45 (op=0b001, I=0, rd=0b1000, rn=0b1111, rm=0b0001) with pc_plus_8_in=0x000008 -> next cycle:
- valid_out=1, opcode_out=1, rd_out=8, rm_out=1.
- rn_out=15 and rd1_out=0x000008.
REQ-034 Writeback with bypass: write R3=0x12345 with rm=3 in the same cycle -> rd2_out=0x12345 that cycle and after the edge.
- Writing R15=0x3FFFFF leaves R15 reads equal to pc8.
REQ-035 Stall vs flush: hold stallD=1 for 3 cycles with changing instruction_in -> outputs frozen.
- Assert stallD=1 and flushD=1 together -> next cycle valid_out=0 and all fields 0.
REQ-036 Sign-extension, with I=1:
- instr[9:0]=0x200 -> imm_ext_out=0x3FFE00.
- instr[9:0]=0x1FF -> imm_ext_out=0x0001FF.
REQ-037 Asynchronous reset: assert reset=0 between clock edges after R5=0x00ABC is written -> valid_out=0 and R5 reads 0 immediately.
- After release, the next load behaves normally.
